area3_load_cm: RTL and testbench

Download-direction counterpart of the area-3 upload scan in the CM811 console path. On i_start, reads a 128-byte block from the CUDB buffer RAM and writes each byte into one of six channel RAMs. The target channel is decoded per byte from the buffer address. Sits between the maintenance/console buffer and the six channel TX RAMs; sequenced by the console controller through i_start / o_done.

---
 rtl/area3_load_cm_pkg.sv | 44 ++++
 rtl/area3_load_cm_if.sv | 29 ++
 rtl/area3_load_cm_rd_pipe.sv | 38 +++
 rtl/area3_load_cm.sv | 131 +++++++++++++
 tb/tb_area3_load_cm.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/area3_load_cm_pkg.sv
// Shared definitions for the area-3 download path: FSM state encoding,
// channel select codes, default sizing and address widths.
package area3_load_cm_pkg;

    localparam int unsigned BLK_LEN_DEF = 128;
    localparam int unsigned RD_LAT_DEF  = 2;
    localparam int unsigned CUDB_AW     = 13;
    localparam int unsigned CH_AW       = 13;
    localparam int unsigned CH_NUM      = 6;
    localparam int unsigned DW          = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_READ  = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_DONE  = 4'b1000
    } state_t;

    typedef enum logic [2:0] {
        CH1 = 3'd0,
        CH2 = 3'd1,
        CH3 = 3'd2,
        CH4 = 3'd3,
        CH5 = 3'd4,
        CH6 = 3'd5
    } ch_sel_t;

    // One-hot channel strobe for a select code; codes 6/7 map to no channel.
    function automatic logic [CH_NUM-1:0] ch_onehot(input logic [2:0] sel);
        logic [CH_NUM-1:0] oh;
        oh = '0;
        case (sel)
            CH1:     oh = 6'b000001;
            CH2:     oh = 6'b000010;
            CH3:     oh = 6'b000100;
            CH4:     oh = 6'b001000;
            CH5:     oh = 6'b010000;
            CH6:     oh = 6'b100000;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/area3_load_cm_if.sv
// Console-side control, CUDB read bus and channel write bus of the
// area-3 download block. master = controller/memories, slave = block.
interface area3_load_cm_if;
    import area3_load_cm_pkg::*;

    logic                i_start;
    logic [9:0]          im_base_addr;
    logic                o_busy;
    logic                o_done;
    logic                o_err;
    logic [CUDB_AW-1:0]  om_cudb_addr;
    logic [DW-1:0]       im_cudb_rdata;
    logic [CH_NUM-1:0]   om_ch_wren;
    logic [CH_AW-1:0]    om_ch_addr;
    logic [DW-1:0]       om_ch_wdata;

    modport master (
        output i_start, im_base_addr, im_cudb_rdata,
        input  o_busy, o_done, o_err, om_cudb_addr,
               om_ch_wren, om_ch_addr, om_ch_wdata
    );

    modport slave (
        input  i_start, im_base_addr, im_cudb_rdata,
        output o_busy, o_done, o_err, om_cudb_addr,
               om_ch_wren, om_ch_addr, om_ch_wdata
    );

endinterface

// File: rtl/area3_load_cm_rd_pipe.sv
// Delay line carrying {valid, address} alongside CUDB read latency so the
// byte address lines up with the returned read data.
module area3_load_cm_rd_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0] vld_sr;
    logic [W-1:0]     dat_sr [DEPTH];

    // Shift valid and address one stage per clock; cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dat_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= in_vld;
            dat_sr[0] <= in_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                dat_sr[i] <= dat_sr[i-1];
            end
        end
    end

    assign out_vld  = vld_sr[DEPTH-1];
    assign out_data = dat_sr[DEPTH-1];

endmodule

// File: rtl/area3_load_cm.sv
// Area-3 download: copies a block from the CUDB buffer RAM into the six
// channel TX RAMs, channel chosen per byte from address bits [12:10].
module area3_load_cm
    import area3_load_cm_pkg::*;
#(
    parameter int unsigned BLK_LEN = BLK_LEN_DEF,
    parameter int unsigned RD_LAT  = RD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    area3_load_cm_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(BLK_LEN + RD_LAT + 1);

    state_t               state_q, state_d;
    logic                 start_blk, issue;
    logic [CNT_W-1:0]     cnt_q;
    logic [CUDB_AW-1:0]   addr_q;
    logic                 rd_vld_q;
    logic                 p_vld;
    logic [CUDB_AW-1:0]   p_addr;
    logic [CH_NUM-1:0]    sel_oh;
    logic                 err_q;
    logic [CH_NUM-1:0]    wren_q;
    logic [CH_AW-1:0]     ch_addr_q;
    logic [DW-1:0]        wdata_q;
    logic                 base_unused;

    assign base_unused = bus.im_base_addr[9];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and per-cycle read control.
    always_comb begin
        state_d   = state_q;
        start_blk = 1'b0;
        issue     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    start_blk = 1'b1;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                if (cnt_q == CNT_W'(BLK_LEN)) state_d = ST_DRAIN;
                else                          issue   = 1'b1;
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(RD_LAT)) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Read address/count; cnt counts issued addresses in READ, then is
    // reused as the drain timer so DONE follows the final write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            cnt_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= start_blk | issue;
            if (start_blk) begin
                addr_q <= {bus.im_base_addr[8:0], 4'd0};
                cnt_q  <= CNT_W'(1);
            end else if (issue) begin
                addr_q <= addr_q + CUDB_AW'(1);
                cnt_q  <= cnt_q + CNT_W'(1);
            end else if (state_q == ST_READ) begin
                cnt_q  <= '0;
            end else if (state_q == ST_DRAIN) begin
                cnt_q  <= cnt_q + CNT_W'(1);
            end
        end
    end

    area3_load_cm_rd_pipe #(
        .DEPTH (RD_LAT),
        .W     (CUDB_AW)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (rd_vld_q),
        .in_data  (addr_q),
        .out_vld  (p_vld),
        .out_data (p_addr)
    );

    assign sel_oh = ch_onehot(p_addr[12:10]);

    // Registered channel write; bus is zero whenever no write happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wren_q    <= '0;
            ch_addr_q <= '0;
            wdata_q   <= '0;
        end else if (p_vld && (sel_oh != '0)) begin
            wren_q    <= sel_oh;
            ch_addr_q <= {3'b000, p_addr[9:0]};
            wdata_q   <= bus.im_cudb_rdata;
        end else begin
            wren_q    <= '0;
            ch_addr_q <= '0;
            wdata_q   <= '0;
        end
    end

    // Sticky invalid-channel flag, reported with done and cleared there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         err_q <= 1'b0;
        else if (state_q == ST_DONE)        err_q <= 1'b0;
        else if (p_vld && (sel_oh == '0))   err_q <= 1'b1;
    end

    assign bus.o_busy       = (state_q != ST_IDLE);
    assign bus.o_done       = (state_q == ST_DONE);
    assign bus.o_err        = (state_q == ST_DONE) & err_q;
    assign bus.om_cudb_addr = addr_q;
    assign bus.om_ch_wren   = wren_q;
    assign bus.om_ch_addr   = ch_addr_q;
    assign bus.om_ch_wdata  = wdata_q;

endmodule

// File: tb/tb_area3_load_cm.sv
// Directed bench for area3_load_cm with a 2-cycle-latency CUDB RAM model.
module tb_area3_load_cm;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cur_cyc = 0;
    int   total_wr;
    int   done_cnt;
    int   ch_cnt [6];
    logic [7:0] rd_p1;

    area3_load_cm_if bus ();

    area3_load_cm #(
        .BLK_LEN (128),
        .RD_LAT  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] cudb_data(input logic [12:0] a);
        return a[7:0] ^ {3'b000, a[12:8]};
    endfunction

    // CUDB RAM: data valid two cycles after the address is presented.
    always @(posedge clk) begin
        rd_p1             <= cudb_data(bus.om_cudb_addr);
        bus.im_cudb_rdata <= rd_p1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cur_cyc, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.o_done), 32'd0);
        chk({tag, "_err"},  32'(bus.o_err),  32'd0);
        chk({tag, "_wren"}, 32'(bus.om_ch_wren), 32'd0);
        chk({tag, "_addr"}, 32'(bus.om_ch_addr), 32'd0);
        chk({tag, "_data"}, 32'(bus.om_ch_wdata), 32'd0);
    endtask

    // Starts a block in the current (negedge) cycle and checks cycles 1..132.
    task automatic run_block(input logic [9:0] base, input bit exp_err, input int restart_cyc);
        logic [12:0] start;
        logic [12:0] a;
        logic [5:0]  ew;
        logic [12:0] ea;
        logic [7:0]  ed;
        start    = {base[8:0], 4'd0};
        total_wr = 0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) ch_cnt[i] = 0;
        bus.im_base_addr = base;
        bus.i_start      = 1'b1;
        for (int c = 1; c <= 132; c++) begin
            @(negedge clk);
            cur_cyc     = c;
            bus.i_start = (c == restart_cyc);
            chk("busy", 32'(bus.o_busy), 32'd1);
            chk("done", 32'(bus.o_done), 32'(c == 132));
            chk("err",  32'(bus.o_err),  32'((c == 132) && exp_err));
            if (c <= 128) chk("cudb_addr", 32'(bus.om_cudb_addr), 32'(start + 13'(c - 1)));
            ew = '0; ea = '0; ed = '0;
            if (c >= 4 && c <= 131) begin
                a = start + 13'(c - 4);
                if (a[12:10] < 3'd6) begin
                    ew = 6'd1 << a[12:10];
                    ea = {3'b000, a[9:0]};
                    ed = cudb_data(a);
                end
            end
            chk("wren",  32'(bus.om_ch_wren),  32'(ew));
            chk("waddr", 32'(bus.om_ch_addr),  32'(ea));
            chk("wdata", 32'(bus.om_ch_wdata), 32'(ed));
            if (bus.om_ch_wren != '0) total_wr++;
            for (int i = 0; i < 6; i++) if (bus.om_ch_wren[i]) ch_cnt[i]++;
            if (bus.o_done) done_cnt++;
        end
    endtask

    initial begin
        rst_n            = 1'b1;
        bus.i_start      = 1'b0;
        bus.im_base_addr = '0;
        #2 rst_n = 1'b0;
        #1;
        chk_idle("reset");
        chk("reset_cudb", 32'(bus.om_cudb_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        // 1: base 0, ch1, data k
        run_block(10'h000, 1'b0, -1);
        chk("t1_ch1", 32'(ch_cnt[0]), 32'd128);
        chk("t1_done", 32'(done_cnt), 32'd1);
        @(negedge clk);
        chk_idle("t1_idle");

        // 2: start 0x1400, all ch6
        run_block(10'h140, 1'b0, -1);
        chk("t2_ch6", 32'(ch_cnt[5]), 32'd128);
        chk("t2_total", 32'(total_wr), 32'd128);
        @(negedge clk);

        // 3: start 0x3C0, crosses into ch2
        run_block(10'h03C, 1'b0, -1);
        chk("t3_ch1", 32'(ch_cnt[0]), 32'd64);
        chk("t3_ch2", 32'(ch_cnt[1]), 32'd64);
        @(negedge clk);

        // 4: start 0x1800, invalid select
        run_block(10'h180, 1'b1, -1);
        chk("t4_total", 32'(total_wr), 32'd0);
        chk("t4_done", 32'(done_cnt), 32'd1);
        @(negedge clk);
        chk_idle("t4_idle");

        // 5: restart while busy ignored; start in DONE ignored; next accepted
        run_block(10'h004, 1'b0, 50);
        chk("t5_total", 32'(total_wr), 32'd128);
        chk("t5_done", 32'(done_cnt), 32'd1);
        bus.i_start = 1'b1;
        @(negedge clk);
        cur_cyc = 133;
        chk("t5_done_start_ignored", 32'(bus.o_busy), 32'd0);
        run_block(10'h001, 1'b0, -1);
        chk("t5b_ch1", 32'(ch_cnt[0]), 32'd128);
        @(negedge clk);

        // 6: reset mid-block abandons it
        bus.im_base_addr = 10'h000;
        bus.i_start      = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            cur_cyc     = c;
            bus.i_start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk_idle("t6_async");
        chk("t6_cudb", 32'(bus.om_cudb_addr), 32'd0);
        for (int c = 61; c <= 62; c++) begin
            @(negedge clk);
            cur_cyc = c;
            chk_idle("t6_hold");
        end
        @(negedge clk);
        rst_n    = 1'b1;
        total_wr = 0;
        done_cnt = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            if (bus.om_ch_wren != '0) total_wr++;
            if (bus.o_done) done_cnt++;
        end
        chk("t6_no_writes", 32'(total_wr), 32'd0);
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        run_block(10'h200, 1'b0, -1);
        chk("t6_ch1", 32'(ch_cnt[0]), 32'd128);
        @(negedge clk);
        chk_idle("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
